// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rxState_t;

  // Registered result bundle presented on the receiver outputs
  typedef struct packed {
    logic [7:0] data;
    logic       ready;
    logic       frameErr;
  } rxOut_t;

  localparam int OVERSAMPLING_DEFAULT = 8;
  localparam int IDLE_GAP_BITS        = 2;

endpackage

// File: rtl/uart_oversample_tick.sv
// Free-running fractional tick generator: accumulates TickRate per clock and
// fires whenever the accumulator wraps past ClkFrequency.
module uart_oversample_tick #(
  parameter int ClkFrequency = 50000000,
  parameter int TickRate     = 921600
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int AccW = $clog2(ClkFrequency) + 1;

  logic [AccW-1:0] acc;
  logic [AccW-1:0] accSum;

  always_comb accSum = acc + AccW'(TickRate);

  // Long-run rate is exact; each tick jitters by at most one clk
  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      tick <= 1'b0;
    end else if (accSum >= AccW'(ClkFrequency)) begin
      acc  <= accSum - AccW'(ClkFrequency);
      tick <= 1'b1;
    end else begin
      acc  <= accSum;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// Oversampling 8N1 UART receiver with 3-sample majority voting, framing-error
// and break handling, and line-idle / end-of-packet detection.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int ClkFrequency = 50000000,
  parameter int Baud         = 115200,
  parameter int Oversampling = OVERSAMPLING_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RxD,
  output logic [7:0] RxD_data,
  output logic       RxD_data_ready,
  output logic       RxD_frame_err,
  output logic       RxD_idle,
  output logic       RxD_endofpacket
);

  generate
    if (ClkFrequency < Baud * Oversampling) begin : gRateTooHigh
      $error("uart_receiver: ClkFrequency must be >= Baud*Oversampling");
    end
    if (Oversampling != 8 && Oversampling != 16) begin : gBadOversampling
      $error("uart_receiver: Oversampling must be 8 or 16");
    end
  endgenerate

  localparam int TickW     = $clog2(Oversampling);
  localparam int IdleTicks = IDLE_GAP_BITS * Oversampling;
  localparam int IdleW     = $clog2(IdleTicks + 1);

  localparam logic [TickW-1:0] VoteLo  = TickW'(Oversampling / 2 - 1);
  localparam logic [TickW-1:0] VoteMid = TickW'(Oversampling / 2);
  localparam logic [TickW-1:0] VoteHi  = TickW'(Oversampling / 2 + 1);
  localparam logic [TickW-1:0] LastTk  = TickW'(Oversampling - 1);

  logic             tick;
  logic             rxSync1, rxSync2;
  rxState_t         state, stateNext;
  logic [TickW-1:0] tickCnt, tickIdx;
  logic [2:0]       bitIdx;
  logic [7:0]       shiftReg;
  logic [1:0]       votes;
  logic             voteBit;
  logic [IdleW-1:0] idleCnt;
  logic             idlePrev;
  logic             byteSeen;
  logic             loadByte, frameErrEv;
  rxOut_t           outReg;

  uart_oversample_tick #(
    .ClkFrequency (ClkFrequency),
    .TickRate     (Baud * Oversampling)
  ) uTick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Index of the tick being processed, within the current bit
  always_comb tickIdx = (tickCnt == LastTk) ? '0 : tickCnt + 1'b1;

  // Two stored samples plus the live one form the 3-sample vote
  always_comb voteBit = (votes[0] & votes[1]) | (votes[0] & rxSync2) | (votes[1] & rxSync2);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (tick) begin
      case (state)
        IDLE:    if (!rxSync2) stateNext = START;
        START: begin
          if (tickIdx == VoteHi && voteBit) stateNext = IDLE;
          else if (tickIdx == '0)           stateNext = DATA;
        end
        DATA:    if (tickIdx == '0 && bitIdx == 3'd7) stateNext = STOP;
        // Decide at mid-stop so a back-to-back start edge is not missed
        STOP:    if (tickIdx == VoteHi) stateNext = voteBit ? IDLE : BREAK;
        BREAK:   if (rxSync2) stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  always_comb begin
    loadByte   = 1'b0;
    frameErrEv = 1'b0;
    if (tick && state == STOP && tickIdx == VoteHi) begin
      loadByte   = voteBit;
      frameErrEv = !voteBit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rxSync1  <= 1'b1;
      rxSync2  <= 1'b1;
      tickCnt  <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
      votes    <= '0;
      idleCnt  <= '0;
      idlePrev <= 1'b0;
      byteSeen <= 1'b0;
      outReg   <= '0;
    end else begin
      rxSync1         <= RxD;
      rxSync2         <= rxSync1;
      outReg.ready    <= loadByte;
      outReg.frameErr <= frameErrEv;
      if (loadByte) outReg.data <= shiftReg;
      idlePrev <= RxD_idle;
      if (outReg.ready)         byteSeen <= 1'b1;
      else if (RxD_endofpacket) byteSeen <= 1'b0;
      if (tick) begin
        // The synchronizer has already swallowed the edge tick, so the
        // detecting tick counts as tick 1 of the start bit
        if (state == IDLE) tickCnt <= TickW'(1);
        else               tickCnt <= tickIdx;
        if (tickIdx == VoteLo)  votes[0] <= rxSync2;
        if (tickIdx == VoteMid) votes[1] <= rxSync2;
        if (state == DATA && tickIdx == VoteHi) shiftReg <= {voteBit, shiftReg[7:1]};
        if (state == IDLE || state == START)       bitIdx <= '0;
        else if (state == DATA && tickIdx == '0)   bitIdx <= bitIdx + 3'd1;
        if (state != IDLE || !rxSync2)             idleCnt <= '0;
        else if (idleCnt != IdleW'(IdleTicks))     idleCnt <= idleCnt + 1'b1;
      end
    end
  end

  assign RxD_data        = outReg.data;
  assign RxD_data_ready  = outReg.ready;
  assign RxD_frame_err   = outReg.frameErr;
  assign RxD_idle        = (idleCnt == IdleW'(IdleTicks));
  assign RxD_endofpacket = RxD_idle & ~idlePrev & byteSeen;

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter ClkFrequency, default 50000000, input clock frequency in Hz.
REQ-002 SHALL have parameter Baud, default 115200, serial bit rate.
REQ-003 SHALL have parameter Oversampling, default 8, sample ticks per bit; legal values 8 or 16.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port RxD  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port RxD_data  output  8  last correctly framed byte.
REQ-008 SHALL have port RxD_data_ready  output  1  one-cycle pulse when RxD_data is updated.
REQ-009 SHALL have port RxD_frame_err  output  1  one-cycle pulse when a stop bit samples low.
REQ-010 SHALL have port RxD_idle  output  1  high while the line has been idle for at least 2 bit times.
REQ-011 SHALL have port RxD_endofpacket  output  1  one-cycle pulse when RxD_idle rises after at least one byte was received.

Function
REQ-012 SHALL fail elaboration if ClkFrequency < Baud*Oversampling.
REQ-013 SHALL pass RxD through a 2-flop synchronizer; both flops reset to 1.
REQ-014 SHALL generate a free-running oversample tick at Baud*Oversampling with an accumulator; error SHALL be under 2% for the default parameters.
REQ-015 SHALL implement states IDLE, START, DATA, STOP and BREAK, with a tick counter (0..Oversampling-1) and a bit index (0..7).
REQ-016 IDLE: on a tick with synchronized RxD = 0 -> START, tick counter cleared.
REQ-017 Each bit SHALL be evaluated by majority vote of 3 samples on ticks Oversampling/2-1, Oversampling/2 and Oversampling/2+1 of the bit.
REQ-018 START: a majority of 1 SHALL be treated as a false start and return to IDLE with no output pulse; a majority of 0 SHALL lead to DATA after Oversampling ticks.
REQ-019 DATA: bits SHALL be shifted in LSB first; after bit 7 completes -> STOP.
REQ-020 STOP: the decision SHALL be made at the mid-bit vote, not at bit end, to allow resynchronization on back-to-back frames.
REQ-021 STOP with majority 1: RxD_data SHALL load the shifted byte and RxD_data_ready SHALL pulse on the following clk; -> IDLE.
REQ-022 STOP with majority 0: RxD_frame_err SHALL pulse, RxD_data SHALL be unchanged and RxD_data_ready SHALL not pulse; -> BREAK.
REQ-023 BREAK: SHALL stay in BREAK until synchronized RxD = 1 on a tick, then -> IDLE.
REQ-024 Idle counter: a saturating count of ticks with synchronized RxD = 1 in IDLE; SHALL clear on any low sample or on leaving IDLE.
REQ-025 RxD_idle SHALL be 1 when the idle counter reaches 2*Oversampling.
REQ-026 RxD_endofpacket SHALL pulse on the cycle RxD_idle rises only if the "byte seen" flag is set; the flag SHALL be set by RxD_data_ready and cleared by RxD_endofpacket.
REQ-027 RxD_data_ready and RxD_frame_err SHALL never be asserted in the same cycle.
REQ-028 End-to-end latency SHALL be: start-bit falling edge to RxD_data_ready = 9.5 bit times ± 1 tick, plus 3 clk.

Reset
REQ-029 rst SHALL override all other activity; state -> IDLE, counters -> 0, byte-seen flag -> 0.
REQ-030 After reset, outputs SHALL be: RxD_data = 8'h00, RxD_data_ready = 0, RxD_frame_err = 0, RxD_idle = 0, RxD_endofpacket = 0.
REQ-031 Reset mid-frame SHALL discard the partial byte; reception SHALL restart only from a fresh falling edge.

Structure
REQ-032 Package uart_pkg SHALL hold the rx state enum, the default Oversampling value and the constant IDLE_GAP_BITS = 2.
REQ-033 Tick generation SHALL be one sub-module, uart_oversample_tick (clk, rst, tick).

Verification
REQ-034 Bench SHALL use ClkFrequency = 921600, Baud = 115200, Oversampling = 8, giving 1 tick/clk and 8 clk/bit.
REQ-035 Send 8'hA5 with 1 stop bit -> RxD_data = 8'hA5 with a single RxD_data_ready pulse 76-79 clk after the start edge.
REQ-036 Send 3-clk low glitch on idle line -> no pulses; state IDLE.
REQ-037 Send 8'h3C with stop bit held low for 20 bit times -> one RxD_frame_err pulse; RxD_data keeps its previous value; the next byte 8'h81 is received correctly after the line goes high.
REQ-038 Send back-to-back 8'h00, 8'hFF, 8'h55, then hold high -> three data_ready pulses in order; RxD_idle rises 16 clk after the last mid-stop; one RxD_endofpacket pulse.
REQ-039 Assert rst during bit 4 of 8'hF0 -> all outputs 0 next clk; no data_ready for that byte; the following 8'h12 is received correctly.
